// File: rtl/seq_mon_pkg.sv
// Shared types and step-prediction helpers for the counter sequence monitor.
package seq_mon_pkg;

    localparam int COUNT_W = 3;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FAULT    = 2'd2
    } seq_state_t;

    function automatic logic [COUNT_W-1:0] bin_next(input logic [COUNT_W-1:0] cur);
        return cur + 3'd1;
    endfunction

    // Reflected Gray order 000,001,011,010,110,111,101,100 then back to 000.
    function automatic logic [COUNT_W-1:0] gray_next(input logic [COUNT_W-1:0] cur);
        logic [COUNT_W-1:0] nxt;
        case (cur)
            3'b000:  nxt = 3'b001;
            3'b001:  nxt = 3'b011;
            3'b011:  nxt = 3'b010;
            3'b010:  nxt = 3'b110;
            3'b110:  nxt = 3'b111;
            3'b111:  nxt = 3'b101;
            3'b101:  nxt = 3'b100;
            3'b100:  nxt = 3'b000;
            default: nxt = 3'b000;
        endcase
        return nxt;
    endfunction

    function automatic logic is_wrap(input logic mode, input logic [COUNT_W-1:0] cur);
        return mode ? (cur == 3'b100) : (cur == 3'b111);
    endfunction

endpackage

// File: rtl/seq_next_calc.sv
// Predicts the next legal counter value and whether that step is a wrap.
// Gray prediction is only built when SEQMON_GRAY_EN is defined.
module seq_next_calc
    import seq_mon_pkg::*;
(
    input  logic               prev_m,
    input  logic [COUNT_W-1:0] prev_count,
    output logic [COUNT_W-1:0] exp_count,
    output logic               wrap
);

    // Select predictor by the mode in effect when the counter stepped.
    always_comb begin
`ifdef SEQMON_GRAY_EN
        if (prev_m) begin
            exp_count = gray_next(prev_count);
        end else begin
            exp_count = bin_next(prev_count);
        end
`else
        exp_count = bin_next(prev_count);
`endif
        wrap = is_wrap(prev_m, prev_count);
    end

endmodule

// File: rtl/count_seq_monitor.sv
// Checks a 3-bit binary/Gray counter step by step and tracks wraps, errors and fault.
// Optional macro SEQMON_GRAY_EN enables checking of Gray-mode (M=1) steps.
module count_seq_monitor
    import seq_mon_pkg::*;
#(
    parameter int ERR_LIMIT = 4,
    parameter int ERR_W     = 4,
    parameter int WRAP_W    = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Enable,
    input  logic               M,
    input  logic [COUNT_W-1:0] Count,
    output logic               Locked,
    output logic               ErrPulse,
    output logic [ERR_W-1:0]   ErrCount,
    output logic [WRAP_W-1:0]  WrapCount,
    output logic               Fault
);

    seq_state_t         state_r;
    logic [COUNT_W-1:0] prev_count_r;
    logic               prev_m_r;
    logic               locked_r;
    logic               err_pulse_r;
    logic               fault_r;
    logic [ERR_W-1:0]   err_cnt_r;
    logic [WRAP_W-1:0]  wrap_cnt_r;

    logic [COUNT_W-1:0] exp_s;
    logic               wrap_s;
    logic               check_en_s;
    logic               mismatch_s;
    logic               wrap_hit_s;
    logic [ERR_W-1:0]   err_inc_s;
    logic [WRAP_W-1:0]  wrap_inc_s;

    seq_next_calc u_next (
        .prev_m     (prev_m_r),
        .prev_count (prev_count_r),
        .exp_count  (exp_s),
        .wrap       (wrap_s)
    );

    // Step classification and saturating increments.
    always_comb begin
`ifdef SEQMON_GRAY_EN
        check_en_s = 1'b1;
`else
        check_en_s = ~prev_m_r;
`endif
        if (check_en_s) begin
            mismatch_s = (Count != exp_s);
            wrap_hit_s = (Count == exp_s) && wrap_s;
        end else begin
            mismatch_s = 1'b0;
            wrap_hit_s = 1'b0;
        end
        if (err_cnt_r == {ERR_W{1'b1}}) begin
            err_inc_s = err_cnt_r;
        end else begin
            err_inc_s = err_cnt_r + ERR_W'(1);
        end
        if (wrap_cnt_r == {WRAP_W{1'b1}}) begin
            wrap_inc_s = wrap_cnt_r;
        end else begin
            wrap_inc_s = wrap_cnt_r + WRAP_W'(1);
        end
    end

    // FSM, sample history and counters; FAULT freezes everything until reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= UNLOCKED;
            prev_count_r <= 3'd0;
            prev_m_r     <= 1'b0;
            locked_r     <= 1'b0;
            err_pulse_r  <= 1'b0;
            fault_r      <= 1'b0;
            err_cnt_r    <= {ERR_W{1'b0}};
            wrap_cnt_r   <= {WRAP_W{1'b0}};
        end else begin
            case (state_r)
                UNLOCKED: begin
                    err_pulse_r <= 1'b0;
                    fault_r     <= 1'b0;
                    if (Enable) begin
                        prev_count_r <= Count;
                        prev_m_r     <= M;
                        state_r      <= LOCKED;
                        locked_r     <= 1'b1;
                    end else begin
                        locked_r     <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (Enable) begin
                        // Resync on every sample so one glitch yields one error.
                        prev_count_r <= Count;
                        prev_m_r     <= M;
                        err_pulse_r  <= mismatch_s;
                        if (mismatch_s) begin
                            err_cnt_r <= err_inc_s;
                            if (err_inc_s == ERR_W'(ERR_LIMIT)) begin
                                state_r  <= FAULT;
                                fault_r  <= 1'b1;
                                locked_r <= 1'b0;
                            end else begin
                                locked_r <= 1'b1;
                            end
                        end else begin
                            locked_r <= 1'b1;
                            if (wrap_hit_s) begin
                                wrap_cnt_r <= wrap_inc_s;
                            end
                        end
                    end else begin
                        state_r     <= UNLOCKED;
                        locked_r    <= 1'b0;
                        err_pulse_r <= 1'b0;
                    end
                end
                FAULT: begin
                    locked_r    <= 1'b0;
                    err_pulse_r <= 1'b0;
                    fault_r     <= 1'b1;
                end
                default: begin
                    state_r     <= UNLOCKED;
                    locked_r    <= 1'b0;
                    err_pulse_r <= 1'b0;
                end
            endcase
        end
    end

    assign Locked    = locked_r;
    assign ErrPulse  = err_pulse_r;
    assign ErrCount  = err_cnt_r;
    assign WrapCount = wrap_cnt_r;
    assign Fault     = fault_r;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed self-checking bench for count_seq_monitor (default parameters).
module tb_count_seq_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Enable = 1'b0;
    logic       M = 1'b0;
    logic [2:0] Count = 3'd0;
    logic       Locked;
    logic       ErrPulse;
    logic [3:0] ErrCount;
    logic [7:0] WrapCount;
    logic       Fault;

    int chk_cnt = 0;
    int fail_cnt = 0;

`ifdef SEQMON_GRAY_EN
    localparam int GRAY_CHK = 1;
`else
    localparam int GRAY_CHK = 0;
`endif

    count_seq_monitor dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Enable    (Enable),
        .M         (M),
        .Count     (Count),
        .Locked    (Locked),
        .ErrPulse  (ErrPulse),
        .ErrCount  (ErrCount),
        .WrapCount (WrapCount),
        .Fault     (Fault)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic m, input logic [2:0] cnt);
        Enable = en;
        M      = m;
        Count  = cnt;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic lk, input logic ep,
                             input int ec, input int wc, input logic ft);
        check_val({tag, "_locked"}, 32'(Locked), 32'(lk));
        check_val({tag, "_errpulse"}, 32'(ErrPulse), 32'(ep));
        check_val({tag, "_errcount"}, 32'(ErrCount), 32'(ec));
        check_val({tag, "_wrapcount"}, 32'(WrapCount), 32'(wc));
        check_val({tag, "_fault"}, 32'(Fault), 32'(ft));
    endtask

    logic [2:0] gray_seq [9] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
    logic [2:0] bad_seq  [5] = '{3'd0, 3'd3, 3'd0, 3'd3, 3'd0};

    initial begin
        // 1: reset with active-looking inputs
        Reset = 1'b1; Enable = 1'b1; Count = 3'd5;
        repeat (2) @(posedge Clk);
        #1;
        check_all("t1_reset", 1'b0, 1'b0, 0, 0, 1'b0);
        Reset = 1'b0;

        // 2: binary sequence with one wrap
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 3'(i % 8));
            check_val("t2_errpulse", 32'(ErrPulse), 32'd0);
            if (i == 0) check_val("t2_locked_first", 32'(Locked), 32'd1);
        end
        check_all("t2_end", 1'b1, 1'b0, 0, 1, 1'b0);

        // 3: Gray sequence, then an illegal Gray step
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, gray_seq[i]);
            check_val("t3_errpulse", 32'(ErrPulse), 32'd0);
        end
        check_all("t3_end", 1'b1, 1'b0, 0, GRAY_CHK, 1'b0);
        step(1'b1, 1'b1, 3'd3);
        check_val("t3_bad_errpulse", 32'(ErrPulse), 32'(GRAY_CHK));
        check_val("t3_bad_errcount", 32'(ErrCount), 32'(GRAY_CHK));

        // 4: single glitch 3->5 flagged once, 5->6 clean
        do_reset();
        step(1'b1, 1'b0, 3'd2);
        step(1'b1, 1'b0, 3'd3);
        check_all("t4_s3", 1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 3'd5);
        check_all("t4_s5", 1'b1, 1'b1, 1, 0, 1'b0);
        step(1'b1, 1'b0, 3'd6);
        check_all("t4_s6", 1'b1, 1'b0, 1, 0, 1'b0);

        // 5: four errors reach the fault limit
        do_reset();
        step(1'b1, 1'b0, bad_seq[0]);
        for (int i = 1; i < 5; i++) begin
            step(1'b1, 1'b0, bad_seq[i]);
            check_val("t5_errpulse", 32'(ErrPulse), 32'd1);
            check_val("t5_errcount", 32'(ErrCount), 32'(i));
        end
        check_all("t5_fault", 1'b0, 1'b1, 4, 0, 1'b1);
        step(1'b1, 1'b0, 3'd3);
        step(1'b1, 1'b0, 3'd7);
        step(1'b0, 1'b1, 3'd2);
        check_all("t5_frozen", 1'b0, 1'b0, 4, 0, 1'b1);
        do_reset();
        check_all("t5_cleared", 1'b0, 1'b0, 0, 0, 1'b0);

        // 6: disable gap with a jump, relock, then clean step
        do_reset();
        step(1'b1, 1'b0, 3'd1);
        step(1'b1, 1'b0, 3'd2);
        check_val("t6_locked_pre", 32'(Locked), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'd6);
            check_val("t6_locked_off", 32'(Locked), 32'd0);
        end
        step(1'b1, 1'b0, 3'd6);
        check_all("t6_relock", 1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 3'd7);
        check_all("t6_clean", 1'b1, 1'b0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Sits directly downstream of the 3-bit mode-selectable counter; samples its Count output and the mode input M.
- Checks every step against the legal sequence: M=0 binary up, M=1 Gray code.
- Reports sequence errors, counts wrap-arounds and errors, and latches a fault after too many errors.
- Used as an on-chip self-check and for lab verification.

Parameters:
- ERR_LIMIT, 4: number of errors that forces the FAULT state (range 1..2^ERR_W-1).
- ERR_W, 4: width of ErrCount.
- WRAP_W, 8: width of WrapCount.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  sample qualifier; Count and M are observed only when 1.
- M  in  1  counter mode driving the upstream counter (0 = binary, 1 = Gray).
- Count  in  3  upstream counter value.
- Locked  out  1  monitor holds a valid previous sample and is checking.
- ErrPulse  out  1  one-cycle strobe for a detected sequence error.
- ErrCount  out  ERR_W  saturating count of errors.
- WrapCount  out  WRAP_W  saturating count of legal wraps.
- Fault  out  1  sticky; ERR_LIMIT errors reached.

Behaviour:
- Clocking and reset
  - Single clock domain.
  - Reset is synchronous, active-high, and has priority over everything else.
  - Reset values: state UNLOCKED; Locked, ErrPulse, Fault = 0; ErrCount, WrapCount = 0; prevCount = 0; prevM = 0.
- Internal registers
  - prevCount[2:0] and prevM capture Count and M on every Enable=1 cycle outside FAULT.
- Expected value
  - exp = next(prevM, prevCount).
  - Binary: prevCount+1 mod 8.
  - Gray sequence: 000, 001, 011, 010, 110, 111, 101, 100, then 000.
- FSM states: UNLOCKED, LOCKED, FAULT.
  - UNLOCKED, Enable=1: capture the sample, go to LOCKED. No check is made on this cycle.
  - LOCKED, Enable=1, Count==exp: no error. If the step is a wrap (binary 7->0, or Gray 100->000), WrapCount increments and saturates at all-ones.
  - LOCKED, Enable=1, Count!=exp:
    - ErrPulse=1 on the next cycle.
    - ErrCount increments and saturates.
    - prevCount/prevM resync to the observed value, so a single glitch causes one error, not a cascade.
    - If the incremented ErrCount equals ERR_LIMIT, go to FAULT.
  - LOCKED or UNLOCKED, Enable=0: go to UNLOCKED, prev registers hold, no check. The first enabled sample after re-enable only relocks.
  - FAULT: Fault=1 and Locked=0. Counters and prev registers are frozen, Enable and inputs are ignored. Only Reset exits FAULT.
- Timing
  - All outputs are registered.
  - ErrPulse, ErrCount and WrapCount update in the cycle after the offending or wrapping sample.
  - Locked=1 in the cycle after the first enabled sample.
- Mode change
  - The check uses prevM, i.e. the mode in effect when the counter stepped.
  - A switch between M=0 and M=1 is therefore checked naturally; no extra skip cycle.
- Simultaneous events
  - Reset overrides Enable, errors and wraps.
  - A sample cannot be both a wrap and an error, since a wrap requires Count==exp.
- Mid-operation reset: all outputs return to reset values on the next edge, and relock is required.

Optional Feature:
- Macro: SEQMON_GRAY_EN.
- Defined: Gray checking on steps with prevM=1, as above.
- Undefined:
  - Steps with prevM=1 are not checked: no error and no wrap counted, but the prev registers still update.
  - The Gray predictor logic is not instantiated.

Decomposition:
- Package seq_mon_pkg holds:
  - COUNT_W = 3.
  - The state enum typedef (UNLOCKED, LOCKED, FAULT).
  - Functions bin_next, gray_next and is_wrap.
- One combinational sub-module, seq_next_calc: inputs prevM and prevCount; outputs exp and the wrap flag.
- Top module holds the FSM, prev registers and counters.

Test Plan:
1. Reset=1 for 2 cycles with Count=5, Enable=1 -> all outputs 0; Locked=0 until one cycle after Reset falls.
2. M=0, Enable=1, Count sequence 0,1,...,7,0 -> Locked=1 from the 2nd cycle, ErrPulse never asserts, WrapCount=1, ErrCount=0.
3. SEQMON_GRAY_EN defined, M=1, Count 000,001,011,010,110,111,101,100,000 -> no errors, WrapCount=1.
   - Same stimulus with the macro undefined -> no errors, WrapCount=0.
4. M=0, Count 2,3,5,6 -> a single ErrPulse in the cycle after 5 is sampled; ErrCount=1; 5->6 is not flagged.
5. ERR_LIMIT=4, four illegal steps (e.g. 0,3,0,3,0):
   - After the 4th error, Fault=1, Locked=0, ErrCount=4.
   - Further bad steps change nothing.
   - Reset=1 for one cycle clears everything.
6. Locked, Count=2; Enable=0 for 3 cycles while Count jumps to 6; Enable=1 with Count 6,7 -> no ErrPulse, Locked=0 for one cycle, then 1; the 6->7 step checks clean.
